// File: rtl/operand_forward_ctrl_pkg.sv
// Shared definitions for the EX-stage operand forwarding controller:
// mux select codes, the destination-tag slot layout and the PC register number.
// Imported by the comparator, the top and the bench.
package operand_forward_ctrl_pkg;

  // Register-number width carried in every tag slot
  localparam int TAG_REG_W = 4;

  // Register number that is never forwarded and never causes a stall
  localparam logic [TAG_REG_W-1:0] PC_REG_NUM = 4'd15;

  // Operand Mux4 select codes
  localparam logic [1:0] SEL_RF   = 2'b00;  // register-file value
  localparam logic [1:0] SEL_MEM  = 2'b01;  // ALU result one stage ahead
  localparam logic [1:0] SEL_WB   = 2'b10;  // result two stages ahead
  localparam logic [1:0] SEL_ZERO = 2'b11;  // operand unused, mux input tied to zero

  // One stage of the private destination-tag pipeline
  typedef struct packed {
    logic                 valid;
    logic [TAG_REG_W-1:0] dst;
    logic                 wb_en;
    logic                 mem_read;
  } tag_slot_t;

  localparam tag_slot_t TAG_BUBBLE = '0;

endpackage

// File: rtl/operand_forward_ctrl_if.sv
// ID-stage instruction info into the forwarding controller and the
// registered operand selects / load-use stall coming back out.
// master = pipeline/ID side, slave = forwarding controller.
interface operand_forward_ctrl_if #(
  parameter int REG_ADDR_W = 4
);
  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_src1;
  logic [REG_ADDR_W-1:0] id_src2;
  logic                  id_src1_used;
  logic                  id_src2_used;
  logic [REG_ADDR_W-1:0] id_dst;
  logic                  id_wb_en;
  logic                  id_mem_read;
  logic                  freeze;
  logic                  flush;
  logic [1:0]            ex_sel1;
  logic [1:0]            ex_sel2;
  logic                  hazard_stall;

  modport master (
    output id_valid, id_src1, id_src2, id_src1_used, id_src2_used,
           id_dst, id_wb_en, id_mem_read, freeze, flush,
    input  ex_sel1, ex_sel2, hazard_stall
  );

  modport slave (
    input  id_valid, id_src1, id_src2, id_src1_used, id_src2_used,
           id_dst, id_wb_en, id_mem_read, freeze, flush,
    output ex_sel1, ex_sel2, hazard_stall
  );

endinterface

// File: rtl/operand_forward_ctrl_fwd_src_match.sv
// Per-source comparator: matches one ID source register against the EX and MEM tags.
// Purely combinational; produces the next operand select and a stall request.
// The caller gates stall_req_o with instruction validity.
module fwd_src_match
  import operand_forward_ctrl_pkg::*;
#(
  parameter int                    REG_ADDR_W = TAG_REG_W,
  parameter bit                    FWD_EN     = 1'b1,
  parameter logic [REG_ADDR_W-1:0] PC_REG     = PC_REG_NUM
) (
  input  logic [REG_ADDR_W-1:0] src_i,
  input  logic                  used_i,
  input  tag_slot_t             ex_slot_i,
  input  tag_slot_t             mem_slot_i,
  output logic [1:0]            sel_o,
  output logic                  stall_req_o
);

  logic ex_hit;
  logic mem_hit;
  logic is_pc;
  logic live;

  assign ex_hit  = ex_slot_i.valid  && ex_slot_i.wb_en  && (ex_slot_i.dst  == src_i);
  assign mem_hit = mem_slot_i.valid && mem_slot_i.wb_en && (mem_slot_i.dst == src_i);
  assign is_pc   = (src_i == PC_REG);
  assign live    = used_i && !is_pc;

  // A load in MEM is already resolved through the WB path, so its flag is not consulted
  logic unused_mem_ld;
  assign unused_mem_ld = mem_slot_i.mem_read;

  // Select: unused operand -> zero, PC -> RF, otherwise newest matching producer wins
  always_comb begin
    sel_o = SEL_RF;
    if (!used_i) begin
      sel_o = SEL_ZERO;
    end else if (is_pc) begin
      sel_o = SEL_RF;
    end else if (FWD_EN) begin
      if (ex_hit) begin
        sel_o = SEL_MEM;
      end else if (mem_hit) begin
        sel_o = SEL_WB;
      end
    end
  end

  // Stall: only a load one ahead when forwarding, any in-flight writer when not
  always_comb begin
    stall_req_o = 1'b0;
    if (FWD_EN) begin
      stall_req_o = live && ex_hit && ex_slot_i.mem_read;
    end else begin
      stall_req_o = live && (ex_hit || mem_hit);
    end
  end

endmodule

// File: rtl/operand_forward_ctrl.sv
// Operand-forwarding controller: registered Mux4 selects for both EX operands plus load-use stall.
// Selects appear one cycle after ID (aligned with the instruction in EX); stall is combinational.
// freeze holds all state; hazard_stall/flush/invalid ID insert a bubble into EX.
module operand_forward_ctrl
  import operand_forward_ctrl_pkg::*;
#(
  parameter int                    REG_ADDR_W = TAG_REG_W,
  parameter bit                    FWD_EN     = 1'b1,
  parameter logic [REG_ADDR_W-1:0] PC_REG     = PC_REG_NUM
) (
  input  logic                   clk,
  input  logic                   rst,
  operand_forward_ctrl_if.slave  fwd
);

  tag_slot_t  ex_q, ex_d;
  tag_slot_t  mem_q;
  tag_slot_t  wb_q;
  logic [1:0] sel1_q, sel1_d;
  logic [1:0] sel2_q, sel2_d;

  logic [1:0] sel1_m, sel2_m;
  logic       stall1_req, stall2_req;
  logic       stall;

  fwd_src_match #(
    .REG_ADDR_W (REG_ADDR_W),
    .FWD_EN     (FWD_EN),
    .PC_REG     (PC_REG)
  ) u_match_src1 (
    .src_i       (fwd.id_src1),
    .used_i      (fwd.id_src1_used),
    .ex_slot_i   (ex_q),
    .mem_slot_i  (mem_q),
    .sel_o       (sel1_m),
    .stall_req_o (stall1_req)
  );

  fwd_src_match #(
    .REG_ADDR_W (REG_ADDR_W),
    .FWD_EN     (FWD_EN),
    .PC_REG     (PC_REG)
  ) u_match_src2 (
    .src_i       (fwd.id_src2),
    .used_i      (fwd.id_src2_used),
    .ex_slot_i   (ex_q),
    .mem_slot_i  (mem_q),
    .sel_o       (sel2_m),
    .stall_req_o (stall2_req)
  );

  // One stall covers both sources, even when they name the same register
  assign stall = fwd.id_valid && (stall1_req || stall2_req);

  // Next EX tag and selects: bubble on flush/stall/empty ID, else capture the ID instruction
  always_comb begin
    ex_d   = TAG_BUBBLE;
    sel1_d = SEL_RF;
    sel2_d = SEL_RF;
    if (fwd.id_valid && !fwd.flush && !stall) begin
      ex_d.valid    = 1'b1;
      ex_d.dst      = fwd.id_dst;
      ex_d.wb_en    = fwd.id_wb_en;
      ex_d.mem_read = fwd.id_mem_read;
      sel1_d        = sel1_m;
      sel2_d        = sel2_m;
    end
  end

  // Tag pipeline and select registers; freeze holds everything in place
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q   <= TAG_BUBBLE;
      mem_q  <= TAG_BUBBLE;
      wb_q   <= TAG_BUBBLE;
      sel1_q <= SEL_RF;
      sel2_q <= SEL_RF;
    end else if (!fwd.freeze) begin
      ex_q   <= ex_d;
      mem_q  <= ex_q;
      wb_q   <= mem_q;
      sel1_q <= sel1_d;
      sel2_q <= sel2_d;
    end
  end

  // The WB tag is tracked for pipeline completeness; the register file covers it, so nothing compares it
  logic unused_wb_tag;
  assign unused_wb_tag = ^wb_q;

  assign fwd.ex_sel1      = sel1_q;
  assign fwd.ex_sel2      = sel2_q;
  assign fwd.hazard_stall = stall;

endmodule

// File: tb/tb_operand_forward_ctrl.sv
// Directed bench for operand_forward_ctrl: one forwarding instance and one stall-only instance
// driven with identical ID streams, hand-computed expected selects and stalls.
module tb_operand_forward_ctrl;
  import operand_forward_ctrl_pkg::*;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  operand_forward_ctrl_if #(.REG_ADDR_W(4)) if1 ();
  operand_forward_ctrl_if #(.REG_ADDR_W(4)) if0 ();

  operand_forward_ctrl #(.REG_ADDR_W(4), .FWD_EN(1'b1), .PC_REG(4'd15)) dut_fwd (
    .clk (clk),
    .rst (rst),
    .fwd (if1)
  );

  operand_forward_ctrl #(.REG_ADDR_W(4), .FWD_EN(1'b0), .PC_REG(4'd15)) dut_nofwd (
    .clk (clk),
    .rst (rst),
    .fwd (if0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic set_id(input logic v, input logic [3:0] s1, input logic u1,
                        input logic [3:0] s2, input logic u2, input logic [3:0] d,
                        input logic wb, input logic mr);
    if1.id_valid = v;  if1.id_src1 = s1; if1.id_src1_used = u1;
    if1.id_src2 = s2;  if1.id_src2_used = u2;
    if1.id_dst = d;    if1.id_wb_en = wb; if1.id_mem_read = mr;
    if0.id_valid = v;  if0.id_src1 = s1; if0.id_src1_used = u1;
    if0.id_src2 = s2;  if0.id_src2_used = u2;
    if0.id_dst = d;    if0.id_wb_en = wb; if0.id_mem_read = mr;
  endtask

  task automatic set_ctl(input logic frz, input logic fl);
    if1.freeze = frz; if1.flush = fl;
    if0.freeze = frz; if0.flush = fl;
  endtask

  task automatic nop();
    set_id(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drain();
    nop();
    repeat (3) tick();
  endtask

  initial begin
    rst = 1'b1;
    set_ctl(1'b0, 1'b0);
    nop();
    #3;
    check("reset_sel1", 32'(if1.ex_sel1), 32'(SEL_RF));
    check("reset_sel2", 32'(if1.ex_sel2), 32'(SEL_RF));
    check("reset_stall", 32'(if1.hazard_stall), 32'd0);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;

    // Back-to-back ALU: ADD R3,R1,R2 ; SUB R5,R3,R4
    set_id(1'b1, 4'd1, 1'b1, 4'd2, 1'b1, 4'd3, 1'b1, 1'b0);
    #1 check("b2b_add_stall", 32'(if1.hazard_stall), 32'd0);
    tick();
    check("b2b_add_sel1", 32'(if1.ex_sel1), 32'(SEL_RF));
    set_id(1'b1, 4'd3, 1'b1, 4'd4, 1'b1, 4'd5, 1'b1, 1'b0);
    #1 check("b2b_sub_stall", 32'(if1.hazard_stall), 32'd0);
    tick();
    check("b2b_sub_sel1", 32'(if1.ex_sel1), 32'(SEL_MEM));
    check("b2b_sub_sel2", 32'(if1.ex_sel2), 32'(SEL_RF));
    drain();

    // Gap of one: ADD R3 ; NOP ; ORR R1,R3,R3
    set_id(1'b1, 4'd1, 1'b1, 4'd2, 1'b1, 4'd3, 1'b1, 1'b0);
    tick();
    nop();
    tick();
    set_id(1'b1, 4'd3, 1'b1, 4'd3, 1'b1, 4'd1, 1'b1, 1'b0);
    tick();
    check("gap_sel1", 32'(if1.ex_sel1), 32'(SEL_WB));
    check("gap_sel2", 32'(if1.ex_sel2), 32'(SEL_WB));
    drain();

    // Priority: two writes of R2, then a read of R2 with src2 unused
    set_id(1'b1, 4'd0, 1'b1, 4'd0, 1'b0, 4'd2, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 4'd1, 1'b1, 4'd0, 1'b0, 4'd2, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 4'd2, 1'b1, 4'd0, 1'b0, 4'd4, 1'b1, 1'b0);
    tick();
    check("prio_sel1", 32'(if1.ex_sel1), 32'(SEL_MEM));
    check("prio_sel2", 32'(if1.ex_sel2), 32'(SEL_ZERO));
    drain();

    // Load-use: LDR R7,[R8] ; ADD R0,R7,R1
    set_id(1'b1, 4'd8, 1'b1, 4'd0, 1'b0, 4'd7, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 4'd7, 1'b1, 4'd1, 1'b1, 4'd0, 1'b1, 1'b0);
    #1;
    check("ld_stall_c1", 32'(if1.hazard_stall), 32'd1);
    check("ld_nofwd_stall_c1", 32'(if0.hazard_stall), 32'd1);
    tick();
    check("ld_bubble_sel1", 32'(if1.ex_sel1), 32'(SEL_RF));
    check("ld_bubble_sel2", 32'(if1.ex_sel2), 32'(SEL_RF));
    check("ld_stall_c2", 32'(if1.hazard_stall), 32'd0);
    check("ld_nofwd_stall_c2", 32'(if0.hazard_stall), 32'd1);
    check("ld_nofwd_bubble_sel1", 32'(if0.ex_sel1), 32'(SEL_RF));
    tick();
    check("ld_use_sel1", 32'(if1.ex_sel1), 32'(SEL_WB));
    check("ld_use_sel2", 32'(if1.ex_sel2), 32'(SEL_RF));
    check("ld_nofwd_stall_c3", 32'(if0.hazard_stall), 32'd0);
    tick();
    check("ld_nofwd_use_sel1", 32'(if0.ex_sel1), 32'(SEL_RF));
    check("ld_nofwd_use_sel2", 32'(if0.ex_sel2), 32'(SEL_RF));
    drain();

    // Freeze for 3 cycles with a forward pending; flush during freeze is ignored
    set_id(1'b1, 4'd1, 1'b1, 4'd2, 1'b1, 4'd3, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 4'd3, 1'b1, 4'd4, 1'b1, 4'd5, 1'b1, 1'b0);
    tick();
    check("frz_pre_sel1", 32'(if1.ex_sel1), 32'(SEL_MEM));
    set_id(1'b1, 4'd3, 1'b1, 4'd0, 1'b0, 4'd6, 1'b1, 1'b0);
    set_ctl(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      set_ctl(1'b1, 1'b0);
      check($sformatf("frz_hold_sel1_%0d", i), 32'(if1.ex_sel1), 32'(SEL_MEM));
      check($sformatf("frz_hold_sel2_%0d", i), 32'(if1.ex_sel2), 32'(SEL_RF));
    end
    set_ctl(1'b0, 1'b0);
    tick();
    // ADD R3 must still be in MEM after the freeze, so the read of R3 takes the WB path
    check("frz_after_sel1", 32'(if1.ex_sel1), 32'(SEL_WB));
    check("frz_after_sel2", 32'(if1.ex_sel2), 32'(SEL_ZERO));
    drain();

    // Flush: ADD R3 ; SUB R3,R3,R4 flushed ; ORR R6,R3
    set_id(1'b1, 4'd1, 1'b1, 4'd2, 1'b1, 4'd3, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 4'd3, 1'b1, 4'd4, 1'b1, 4'd3, 1'b1, 1'b0);
    set_ctl(1'b0, 1'b1);
    tick();
    set_ctl(1'b0, 1'b0);
    check("flush_sel1", 32'(if1.ex_sel1), 32'(SEL_RF));
    check("flush_sel2", 32'(if1.ex_sel2), 32'(SEL_RF));
    set_id(1'b1, 4'd3, 1'b1, 4'd0, 1'b0, 4'd6, 1'b1, 1'b0);
    tick();
    check("flush_bubble_sel1", 32'(if1.ex_sel1), 32'(SEL_WB));
    drain();

    // PC register: load into R15, then read R15 on both sources
    set_id(1'b1, 4'd0, 1'b1, 4'd0, 1'b0, 4'd15, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 4'd15, 1'b1, 4'd15, 1'b1, 4'd2, 1'b1, 1'b0);
    #1;
    check("pc_stall", 32'(if1.hazard_stall), 32'd0);
    check("pc_nofwd_stall", 32'(if0.hazard_stall), 32'd0);
    tick();
    check("pc_sel1", 32'(if1.ex_sel1), 32'(SEL_RF));
    check("pc_sel2", 32'(if1.ex_sel2), 32'(SEL_RF));
    // Unused operands, src1 names R2 which is in EX
    set_id(1'b1, 4'd2, 1'b0, 4'd15, 1'b0, 4'd4, 1'b1, 1'b0);
    tick();
    check("unused_sel1", 32'(if1.ex_sel1), 32'(SEL_ZERO));
    check("unused_sel2", 32'(if1.ex_sel2), 32'(SEL_ZERO));
    check("unused_nofwd_sel1", 32'(if0.ex_sel1), 32'(SEL_ZERO));
    drain();

    // Reset mid-run with all slots valid and a load-use stall pending
    set_id(1'b1, 4'd1, 1'b1, 4'd0, 1'b0, 4'd3, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 4'd2, 1'b1, 4'd0, 1'b0, 4'd4, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 4'd4, 1'b1, 4'd0, 1'b0, 4'd7, 1'b1, 1'b1);
    tick();
    check("rst_pre_sel1", 32'(if1.ex_sel1), 32'(SEL_MEM));
    set_id(1'b1, 4'd7, 1'b1, 4'd0, 1'b0, 4'd0, 1'b1, 1'b0);
    #1 check("rst_pre_stall", 32'(if1.hazard_stall), 32'd1);
    rst = 1'b1;
    #1;
    check("rst_mid_sel1", 32'(if1.ex_sel1), 32'(SEL_RF));
    check("rst_mid_sel2", 32'(if1.ex_sel2), 32'(SEL_ZERO) & 32'(SEL_RF));
    check("rst_mid_stall", 32'(if1.hazard_stall), 32'd0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1 check("rst_post_stall", 32'(if1.hazard_stall), 32'd0);
    tick();
    check("rst_post_sel1", 32'(if1.ex_sel1), 32'(SEL_RF));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
